// File: rtl/zion_rr_arb_dff_stage.sv
// Round-robin arbiter that merges NUM_REQ valid/ready requesters into one
// shared registered output stage carrying data, valid and the source index.
module zion_rr_arb_dff_stage #(
    parameter int              NUM_REQ  = 4,
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0,
    localparam int             SRC_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       iVld,
    output logic [NUM_REQ-1:0]       iRdy,
    input  logic [NUM_REQ*WIDTH-1:0] iDat,
    output logic                     oVld,
    input  logic                     oRdy,
    output logic [WIDTH-1:0]         oDat,
    output logic [SRC_W-1:0]         oSrc
);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : gBadNumReq
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_rr_arb_dff_stage: NUM_REQ must be within 2..16");
`else
        $error("zion_rr_arb_dff_stage: NUM_REQ must be within 2..16");
`endif
    end

    logic                 oVldQ, oVldD;
    logic [WIDTH-1:0]     oDatQ, oDatD;
    logic [SRC_W-1:0]     oSrcQ, oSrcD;
    logic [SRC_W-1:0]     ptrQ, ptrD;
    logic [SRC_W-1:0]     win;
    logic [SRC_W-1:0]     cand;
    logic                 found;
    logic                 ld;
    logic                 grant;
    logic [WIDTH-1:0]     datArr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : gUnpack
        assign datArr[k] = iDat[k*WIDTH +: WIDTH];
    end

    assign ld    = !oVldQ || oRdy;
    assign grant = ld && found;

    // Search starts just past the last winner and wraps, so the previous
    // winner has the lowest priority in the next round.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = SRC_W'((int'(ptrQ) + off) % NUM_REQ);
            if (!found && iVld[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        iRdy = '0;
        if (grant) begin
            iRdy[win] = 1'b1;
        end
    end

    always_comb begin
        oVldD = oVldQ;
        oDatD = oDatQ;
        oSrcD = oSrcQ;
        ptrD  = ptrQ;
        if (grant) begin
            oVldD = 1'b1;
            oDatD = datArr[win];
            oSrcD = win;
            ptrD  = win;
        end else if (oRdy) begin
            oVldD = 1'b0;
        end
    end

    // Pointer resets to the top index so requester 0 is the first winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oVldQ <= 1'b0;
            oDatQ <= INI_DATA;
            oSrcQ <= '0;
            ptrQ  <= SRC_W'(NUM_REQ - 1);
        end else begin
            oVldQ <= oVldD;
            oDatQ <= oDatD;
            oSrcQ <= oSrcD;
            ptrQ  <= ptrD;
        end
    end

    assign oVld = oVldQ;
    assign oDat = oDatQ;
    assign oSrc = oSrcQ;

endmodule

// File: tb/tb_zion_rr_arb_dff_stage.sv
// Directed plus constrained-random bench for the round-robin register stage,
// with a scoreboard of expected post-edge output states.
module tb_zion_rr_arb_dff_stage;

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic [1:0]  src;
    } beat_t;

    logic         clk;
    logic         rst;
    logic [3:0]   iVld;
    logic [3:0]   iRdy;
    logic [127:0] iDat;
    logic         oVld;
    logic         oRdy;
    logic [31:0]  oDat;
    logic [1:0]   oSrc;
    logic [31:0]  dat [4];

    logic [2:0]   iVld3;
    logic [2:0]   iRdy3;
    logic [23:0]  iDat3;
    logic         oVld3;
    logic         oRdy3;
    logic [7:0]   oDat3;
    logic [1:0]   oSrc3;

    int           checks;
    int           errors;
    beat_t        sb [$];
    beat_t        mBeat;
    logic [1:0]   mPtr;
    logic [3:0]   mRdy;
    logic [3:0]   hold;
    logic [3:0]   rv;
    logic [1:0]   seq [6];
    logic [7:0]   d3 [3];

    assign iDat  = {dat[3], dat[2], dat[1], dat[0]};
    assign iDat3 = {8'h33, 8'h22, 8'h11};

    zion_rr_arb_dff_stage #(.NUM_REQ(4), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .iVld(iVld), .iRdy(iRdy), .iDat(iDat),
        .oVld(oVld), .oRdy(oRdy), .oDat(oDat), .oSrc(oSrc)
    );

    zion_rr_arb_dff_stage #(.NUM_REQ(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .iVld(iVld3), .iRdy(iRdy3), .iDat(iDat3),
        .oVld(oVld3), .oRdy(oRdy3), .oDat(oDat3), .oSrc(oSrc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        sb.delete();
        mBeat = '{vld: 1'b0, dat: 32'h0, src: 2'd0};
        mPtr  = 2'd3;
    endtask

    // Drive one cycle of inputs, check the combinational grant, and queue the
    // state the stage must hold after the coming edge.
    task automatic applyStimulus(input logic [3:0] v, input logic r);
        logic       ldM;
        logic       foundM;
        logic [1:0] w;
        beat_t      nxt;
        iVld = v;
        oRdy = r;
        #1;
        ldM    = !mBeat.vld || r;
        foundM = 1'b0;
        w      = 2'd0;
        for (int off = 1; off <= 4; off++) begin
            if (!foundM && v[(int'(mPtr) + off) % 4]) begin
                foundM = 1'b1;
                w      = 2'((int'(mPtr) + off) % 4);
            end
        end
        mRdy = (ldM && foundM) ? (4'b0001 << w) : 4'b0000;
        chk("iRdy", {28'h0, iRdy}, {28'h0, mRdy});
        nxt = mBeat;
        if (ldM && foundM) begin
            nxt  = '{vld: 1'b1, dat: dat[w], src: w};
            mPtr = w;
        end else if (r) begin
            nxt.vld = 1'b0;
        end
        sb.push_back(nxt);
        mBeat = nxt;
    endtask

    task automatic checkOutput();
        beat_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk("oVld", {31'h0, oVld}, {31'h0, e.vld});
            chk("oDat", oDat, e.dat);
            chk("oSrc", {30'h0, oSrc}, {30'h0, e.src});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hold   = 4'b0000;
        seq    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        d3     = '{8'h11, 8'h22, 8'h33};
        rst    = 1'b0;
        iVld   = 4'b0000;
        oRdy   = 1'b0;
        iVld3  = 3'b000;
        oRdy3  = 1'b0;
        for (int k = 0; k < 4; k++) dat[k] = 32'h0;
        resetModel();

        #2;
        chk("rstVld", {31'h0, oVld}, 32'h0);
        chk("rstDat", oDat, 32'h0);
        chk("rstSrc", {30'h0, oSrc}, 32'h0);
        chk("rstRdy", {28'h0, iRdy}, 32'h0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Two sparse requesters, round-robin between them.
        dat[0] = 32'hA;
        dat[2] = 32'hC;
        applyStimulus(4'b0101, 1'b1);
        chk("plan1Rdy0", {28'h0, iRdy}, 32'h1);
        checkOutput();
        chk("plan1Dat0", oDat, 32'hA);
        chk("plan1Src0", {30'h0, oSrc}, 32'h0);
        applyStimulus(4'b0101, 1'b1);
        chk("plan1Rdy1", {28'h0, iRdy}, 32'h4);
        checkOutput();
        chk("plan1Dat1", oDat, 32'hC);
        chk("plan1Src1", {30'h0, oSrc}, 32'h2);
        applyStimulus(4'b0000, 1'b1);
        checkOutput();

        // Asynchronous reset between edges while a beat is held.
        for (int k = 0; k < 4; k++) dat[k] = 32'h100 + k;
        applyStimulus(4'b1111, 1'b1);
        checkOutput();
        chk("preRstVld", {31'h0, oVld}, 32'h1);
        iVld = 4'b0000;
        rst  = 1'b0;
        #1;
        chk("asyncVld", {31'h0, oVld}, 32'h0);
        chk("asyncDat", oDat, 32'h0);
        chk("asyncSrc", {30'h0, oSrc}, 32'h0);
        resetModel();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full throughput with everybody requesting.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b1111, 1'b1);
            checkOutput();
            chk("seqSrc", {30'h0, oSrc}, {30'h0, seq[i]});
            chk("seqVld", {31'h0, oVld}, 32'h1);
        end

        // Stall holds the beat and freezes the pointer.
        dat[2] = 32'h55;
        applyStimulus(4'b0100, 1'b1);
        checkOutput();
        chk("stallLoad", oDat, 32'h55);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 1'b0);
            chk("stallRdy", {28'h0, iRdy}, 32'h0);
            checkOutput();
            chk("stallDat", oDat, 32'h55);
            chk("stallSrc", {30'h0, oSrc}, 32'h2);
        end
        applyStimulus(4'b1111, 1'b1);
        chk("resumeRdy", {28'h0, iRdy}, 32'h8);
        checkOutput();

        // Single beat from requester 3, then drain.
        applyStimulus(4'b0000, 1'b1);
        checkOutput();
        dat[3] = 32'hDEAD0003;
        applyStimulus(4'b1000, 1'b1);
        checkOutput();
        chk("pulseVld", {31'h0, oVld}, 32'h1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput();
        chk("pulseEnd", {31'h0, oVld}, 32'h0);
        chk("pulseHold", oDat, 32'hDEAD0003);
        applyStimulus(4'b0000, 1'b1);
        checkOutput();

        // Random traffic obeying the hold-until-transfer rule.
        for (int n = 0; n < 32; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (!hold[k]) dat[k] = $urandom;
            end
            rv = hold | 4'($urandom_range(0, 15));
            applyStimulus(rv, 1'($urandom_range(0, 1)));
            hold = rv & ~mRdy;
            checkOutput();
        end
        iVld = 4'b0000;

        // Non power-of-two instance never selects index 3.
        iVld3 = 3'b111;
        oRdy3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("nr3Src", {30'h0, oSrc3}, 32'(i % 3));
            chk("nr3Dat", {24'h0, oDat3}, {24'h0, d3[i % 3]});
            chk("nr3Vld", {31'h0, oVld3}, 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
